// File: rtl/i2c_master_core.sv
// Transaction-level I2C master: 7-bit addressing, multi-byte read/write bursts,
// ACK checking and valid/ready host streams, with SCL built from quarter ticks.
module i2c_master_core #(
   parameter int CLK_DIV = 25,
   parameter int LEN_W   = 4,
   parameter int ADDR_W  = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [7:0]        tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              done,
   output logic              ack_err,
   output logic              scl,
   inout  wire               sda
);
   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
   } state_t;

   localparam int DIV_W = $clog2(CLK_DIV);

   state_t           state, state_nx;
   logic [1:0]       rst_sync;
   logic             rst_n;
   logic [DIV_W-1:0] div;
   logic [1:0]       q;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [LEN_W-1:0] remaining;
   logic             rw, loaded, ack_bit, sda_low, sda_in;
   logic             tick, stall, cell_end, sample, accept;

   // Reset asserts asynchronously but is released in step with clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign sda      = sda_low ? 1'b0 : 1'bz;
   assign sda_in   = sda;
   assign accept   = cmd_valid && cmd_ready;
   // The first quarter of a write byte waits here until the host supplies data.
   assign stall    = (state == WR_BYTE) && !loaded && !tx_valid;
   assign tick     = (state != IDLE) && !stall && (div == DIV_W'(CLK_DIV - 1));
   assign cell_end = tick && (q == 2'd3);
   assign sample   = tick && (q == 2'd1);

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (accept) state_nx = START;
         START:    if (cell_end) state_nx = ADDR;
         ADDR:     if (cell_end && bit_cnt == 3'd7) state_nx = ADDR_ACK;
         ADDR_ACK: if (cell_end) begin
            if (ack_bit || remaining == '0) state_nx = STOP;
            else if (rw)                    state_nx = RD_BYTE;
            else                            state_nx = WR_BYTE;
         end
         WR_BYTE:  if (cell_end && bit_cnt == 3'd7) state_nx = WR_ACK;
         WR_ACK:   if (cell_end) state_nx = (ack_bit || remaining == LEN_W'(1)) ? STOP : WR_BYTE;
         RD_BYTE:  if (cell_end && bit_cnt == 3'd7) state_nx = RD_ACK;
         RD_ACK:   if (cell_end) state_nx = (remaining == LEN_W'(1)) ? STOP : RD_BYTE;
         STOP:     if (cell_end) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      scl       = 1'b1;
      sda_low   = 1'b0;
      tx_ready  = 1'b0;
      busy      = (state != IDLE);
      cmd_ready = (state == IDLE) && !done;
      unique case (state)
         START: begin
            scl     = (q != 2'd3);
            sda_low = q[1];
         end
         ADDR: begin
            scl     = q[0] ^ q[1];
            sda_low = !shreg[7];
         end
         WR_BYTE: begin
            scl      = q[0] ^ q[1];
            sda_low  = loaded && !shreg[7];
            tx_ready = !loaded && tx_valid;
         end
         ADDR_ACK, WR_ACK, RD_BYTE: scl = q[0] ^ q[1];
         RD_ACK: begin
            scl     = q[0] ^ q[1];
            sda_low = (remaining != LEN_W'(1));
         end
         STOP: begin
            scl     = (q != 2'd0);
            sda_low = (q != 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div       <= '0;
         q         <= 2'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         remaining <= '0;
         rw        <= 1'b0;
         loaded    <= 1'b0;
         ack_bit   <= 1'b0;
         ack_err   <= 1'b0;
         done      <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
      end else begin
         done     <= (state == STOP) && cell_end;
         rx_valid <= 1'b0;
         if (state == IDLE) begin
            div <= '0;
            q   <= 2'd0;
         end else if (!stall) begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) q <= q + 2'd1;
         end
         if (accept) begin
            rw        <= cmd_rw;
            remaining <= cmd_len;
            shreg     <= {cmd_addr, cmd_rw};
            bit_cnt   <= 3'd0;
            ack_err   <= 1'b0;
         end
         if (tx_ready) begin
            shreg  <= tx_data;
            loaded <= 1'b1;
         end
         if (sample) begin
            ack_bit <= sda_in;
            if (state == RD_BYTE) begin
               shreg <= {shreg[6:0], sda_in};
               if (bit_cnt == 3'd7) begin
                  rx_data  <= {shreg[6:0], sda_in};
                  rx_valid <= 1'b1;
               end
            end
         end
         if (cell_end) begin
            if (state inside {ADDR, WR_BYTE, RD_BYTE}) bit_cnt <= bit_cnt + 3'd1;
            if (state == ADDR || state == WR_BYTE)    shreg <= {shreg[6:0], 1'b0};
            if ((state == ADDR_ACK || state == WR_ACK) && ack_bit) ack_err <= 1'b1;
            if (state == WR_ACK || state == RD_ACK)   remaining <= remaining - LEN_W'(1);
            if (state != WR_BYTE && state_nx == WR_BYTE) loaded <= 1'b0;
         end
      end
   end
endmodule
